// File: rtl/gate_checker.sv
// gate_checker: drives the four input vectors into an external 2-input gate and checks its output.
// Optional run-failure counter (err_count) is built when GATE_CHECKER_COUNT_EN is defined.
module gate_checker #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] op,
   output logic       dut_in1,
   output logic       dut_in2,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic       err_op
`ifdef GATE_CHECKER_COUNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   function automatic logic gate_eval(input logic [3:0] sel, input logic a, input logic b);
      logic r;
      case (sel)
         4'd0:    r = a;
         4'd1:    r = 1'b0;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = ~a;
         4'd5:    r = ~(a | b);
         4'd6:    r = a ^ b;
         4'd7:    r = ~(a & b);
         4'd8:    r = ~(a ^ b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   logic [1:0] state_r, state_s;
   logic [3:0] op_r;
   logic [1:0] vec_r, vec_s;
   logic [3:0] cnt_r, cnt_s;
   logic [3:0] fail_mask_s;
   logic       pass_s, err_op_s;
   logic       busy_s, done_s, in1_s, in2_s;
   logic       op_ok_s, miss_s;

   assign op_ok_s = (op <= 4'd8);
   assign miss_s  = (dut_out != gate_eval(op_r, vec_r[1], vec_r[0]));

   // Next-state and result update; results are cleared on an accepted start
   always_comb begin
      state_s     = state_r;
      vec_s       = vec_r;
      cnt_s       = cnt_r;
      fail_mask_s = fail_mask;
      pass_s      = pass;
      err_op_s    = err_op;
      case (state_r)
         IDLE: begin
            if (start) begin
               vec_s    = 2'd0;
               cnt_s    = 4'd0;
               pass_s   = 1'b0;
               if (op_ok_s) begin
                  state_s     = DRIVE;
                  fail_mask_s = 4'h0;
                  err_op_s    = 1'b0;
               end else begin
                  state_s     = DONE;
                  fail_mask_s = 4'hF;
                  err_op_s    = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         DRIVE: begin
            if (cnt_r == SETTLE_LAST) begin
               state_s = SAMPLE;
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         SAMPLE: begin
            cnt_s = 4'd0;
            if (miss_s) begin
               fail_mask_s = fail_mask | (4'b0001 << vec_r);
            end else begin
               fail_mask_s = fail_mask;
            end
            // pass is resolved here so it is valid in the same cycle as done
            if (vec_r == 2'd3) begin
               state_s = DONE;
               pass_s  = (fail_mask_s == 4'h0);
            end else begin
               state_s = DRIVE;
               vec_s   = vec_r + 2'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output values for the coming state; they are registered below
   always_comb begin
      busy_s = 1'b0;
      in1_s  = 1'b0;
      in2_s  = 1'b0;
      if ((state_s == DRIVE) || (state_s == SAMPLE)) begin
         busy_s = 1'b1;
         in1_s  = vec_s[1];
         in2_s  = vec_s[0];
      end else begin
         busy_s = 1'b0;
         in1_s  = 1'b0;
         in2_s  = 1'b0;
      end
      done_s = (state_s == DONE);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         op_r      <= 4'd0;
         vec_r     <= 2'd0;
         cnt_r     <= 4'd0;
         dut_in1   <= 1'b0;
         dut_in2   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= 4'h0;
         err_op    <= 1'b0;
      end else begin
         state_r   <= state_s;
         op_r      <= ((state_r == IDLE) && start) ? op : op_r;
         vec_r     <= vec_s;
         cnt_r     <= cnt_s;
         dut_in1   <= in1_s;
         dut_in2   <= in2_s;
         busy      <= busy_s;
         done      <= done_s;
         pass      <= pass_s;
         fail_mask <= fail_mask_s;
         err_op    <= err_op_s;
      end
   end

`ifdef GATE_CHECKER_COUNT_EN
   // Saturating count of runs that end without a pass
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= 8'd0;
      end else if ((state_s == DONE) && !pass_s && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end else begin
         err_count <= err_count;
      end
   end
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: a truth-table gate model feeds dut_out and a
// truth-table reference predicts latency, fail_mask, pass and err_op.
module tb_gate_checker;
   localparam int SETTLE = 2;
   localparam int LAT    = 4 * (SETTLE + 1) + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] op;
   logic       dut_in1, dut_in2, dut_out;
   logic       busy, done, pass, err_op;
   logic [3:0] fail_mask;
   logic [3:0] model_tt;
`ifdef GATE_CHECKER_COUNT_EN
   logic [7:0] err_count;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // The gate under test: bit v of model_tt is its output for vector v = {in1,in2}
   assign dut_out = model_tt[{dut_in1, dut_in2}];

   gate_checker #(.SETTLE(SETTLE)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .dut_in1   (dut_in1),
      .dut_in2   (dut_in2),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_mask (fail_mask),
      .err_op    (err_op)
`ifdef GATE_CHECKER_COUNT_EN
      ,
      .err_count (err_count)
`endif
   );

   function automatic logic [3:0] tt_of(input logic [3:0] g);
      case (g)
         4'd0:    return 4'b1100;
         4'd1:    return 4'b0000;
         4'd2:    return 4'b1000;
         4'd3:    return 4'b1110;
         4'd4:    return 4'b0011;
         4'd5:    return 4'b0001;
         4'd6:    return 4'b0110;
         4'd7:    return 4'b0111;
         4'd8:    return 4'b1001;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic do_run(input logic [3:0] op_v, input logic [3:0] mtt, input bit repulse, input string name);
      bit         valid;
      int         lat, done_cyc, done_cnt;
      bit         in_bad, busy_bad;
      logic [3:0] exp_fm, got_fm;
      logic       exp_pass, got_pass, got_err;
      logic [1:0] ev;
      valid    = (op_v <= 4'd8);
      lat      = valid ? LAT : 1;
      exp_fm   = valid ? (tt_of(op_v) ^ mtt) : 4'hF;
      exp_pass = valid && (exp_fm == 4'h0);
      model_tt = mtt;
      done_cyc = -1; done_cnt = 0; in_bad = 1'b0; busy_bad = 1'b0;
      got_fm = 4'bx; got_pass = 1'bx; got_err = 1'bx;
      @(negedge clk);
      start = 1'b1;
      op    = op_v;
      for (int c = 1; c <= lat + 4; c++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c; got_pass = pass; got_fm = fail_mask; got_err = err_op;
            end
         end
         ev = 2'((c - 1) / (SETTLE + 1));
         if (valid && (c < lat)) begin
            if ({dut_in1, dut_in2} !== ev) in_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
         end else begin
            if ({dut_in1, dut_in2} !== 2'b00) in_bad = 1'b1;
            if ((c > lat) && (busy !== 1'b0)) busy_bad = 1'b1;
         end
         start = repulse && (c == 5);
         op    = (repulse && (c == 5)) ? 4'd7 : 4'($urandom);
      end
      start = 1'b0;
      checks++;
      if (done_cyc !== lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, done_cyc, lat); end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt); end
      checks++;
      if (got_fm !== exp_fm) begin errors++; $display("FAIL %s fail_mask: got %b expected %b", name, got_fm, exp_fm); end
      checks++;
      if (got_pass !== exp_pass) begin errors++; $display("FAIL %s pass: got %b expected %b", name, got_pass, exp_pass); end
      checks++;
      if (got_err !== !valid) begin errors++; $display("FAIL %s err_op: got %b expected %b", name, got_err, !valid); end
      checks++;
      if (in_bad) begin errors++; $display("FAIL %s vectors: got wrong dut_in sequence expected v=(c-1)/%0d", name, SETTLE + 1); end
      checks++;
      if (busy_bad) begin errors++; $display("FAIL %s busy: got wrong busy profile expected high while driving", name); end
      checks++;
      if ({pass, fail_mask, err_op} !== {exp_pass, exp_fm, !valid}) begin
         errors++; $display("FAIL %s hold: got %b expected %b", name, {pass, fail_mask, err_op}, {exp_pass, exp_fm, !valid});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 4'd0; model_tt = 4'b0000;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, dut_in1, dut_in2, pass, err_op, fail_mask} !== 10'b0) begin
         errors++; $display("FAIL reset_state: got %b expected 0", {busy, done, dut_in1, dut_in2, pass, err_op, fail_mask});
      end
      start = 1'b1; op = 4'd2;
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, dut_in1, dut_in2} !== 4'b0) begin
         errors++; $display("FAIL rst_priority: got %b expected 0000", {busy, done, dut_in1, dut_in2});
      end
   endtask

   task automatic test_and_pass();
      do_run(4'd2, tt_of(4'd2), 1'b0, "and_pass");
   endtask

   task automatic test_xor_vs_or();
      do_run(4'd6, tt_of(4'd3), 1'b0, "xor_vs_or");
   endtask

   task automatic test_invalid_op();
      do_run(4'd9, 4'b1111, 1'b0, "invalid_op");
   endtask

   task automatic test_reset_mid_run();
      logic fm0;
      model_tt = 4'b1001;
      @(negedge clk);
      start = 1'b1; op = 4'd2;
      fm0 = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 6) begin fm0 = fail_mask[0]; rst = 1'b1; end
      end
      checks++;
      if (fm0 !== 1'b1) begin errors++; $display("FAIL midrun_mask: got %b expected 1", fm0); end
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, dut_in1, dut_in2, pass, err_op, fail_mask} !== 10'b0) begin
         errors++; $display("FAIL midrun_reset: got %b expected 0", {busy, done, dut_in1, dut_in2, pass, err_op, fail_mask});
      end
      do_run(4'd3, tt_of(4'd3), 1'b0, "or_after_rst");
   endtask

   task automatic test_back_to_back();
      do_run(4'd2, tt_of(4'd2), 1'b1, "restart_ignored");
      do_run(4'd8, tt_of(4'd8), 1'b0, "xnor_next");
   endtask

   task automatic test_random();
      logic [3:0] g, m;
      for (int i = 0; i < 12; i++) begin
         g = 4'($urandom_range(0, 15));
         m = ($urandom_range(0, 1) == 0) ? tt_of(g) : 4'($urandom);
         do_run(g, m, 1'b0, $sformatf("rand%0d", i));
      end
   endtask

`ifdef GATE_CHECKER_COUNT_EN
   task automatic test_err_count();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL errcnt_init: got %0d expected 0", err_count); end
      do_run(4'd9, 4'b0000, 1'b0, "cnt_invalid");
      do_run(4'd6, tt_of(4'd3), 1'b0, "cnt_xor");
      do_run(4'd2, 4'b1001, 1'b0, "cnt_and_bad");
      do_run(4'd2, tt_of(4'd2), 1'b0, "cnt_and_ok");
      checks++;
      if (err_count !== 8'd3) begin errors++; $display("FAIL errcnt_three: got %0d expected 3", err_count); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL errcnt_rst: got %0d expected 0", err_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_and_pass();
      test_xor_vs_or();
      test_invalid_op();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
`ifdef GATE_CHECKER_COUNT_EN
      test_err_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
